// File: rtl/immt.sv
// rtl/immt.sv - immediate type encoding shared by the packer and the ALU unpacker
package immt;

  typedef enum logic [1:0] {
    i = 2'd0,
    u = 2'd1,
    j = 2'd2,
    b = 2'd3
  } imm_type_t;

endpackage

// File: rtl/imm_pack_stage.sv
// rtl/imm_pack_stage.sv - RV32I immediate packer stage with 2-entry skid buffer
module imm_pack_stage #(
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [19:0]      out_imm,
  output immt::imm_type_t  out_type,
  output logic             out_illegal,
  output logic [TAG_W-1:0] out_tag
);

  // Encoding is {M.v, S.v}; the S-only combination can never be reached.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_ONE   = 2'b10,
    ST_FULL  = 2'b11
  } state_t;

  state_t state_q, state_d;

  logic [19:0]      pk_imm;
  immt::imm_type_t  pk_type;
  logic             pk_ill;

  logic [19:0]      m_imm_q, m_imm_d;
  immt::imm_type_t  m_type_q, m_type_d;
  logic             m_ill_q, m_ill_d;
  logic [TAG_W-1:0] m_tag_q, m_tag_d;

  logic [19:0]      s_imm_q, s_imm_d;
  immt::imm_type_t  s_type_q, s_type_d;
  logic             s_ill_q, s_ill_d;
  logic [TAG_W-1:0] s_tag_q, s_tag_d;

  logic accept, drain, load_m, load_s, move_s;

  // Pack the immediate so that the unpacker only needs fixed bit shuffles per type.
  always_comb begin
    pk_imm  = 20'h0;
    pk_type = immt::i;
    pk_ill  = 1'b0;
    case (in_inst[6:0])
      7'h37, 7'h17: begin
        pk_imm  = in_inst[31:12];
        pk_type = immt::u;
      end
      7'h6F: begin
        pk_imm  = in_inst[31:12];
        pk_type = immt::j;
      end
      7'h63: begin
        pk_imm  = {in_inst[31:25], in_inst[11:8], in_inst[7], 8'h00};
        pk_type = immt::b;
      end
      7'h23: begin
        pk_imm  = {in_inst[31:25], in_inst[11:8], in_inst[7], 8'h00};
      end
      7'h03, 7'h67, 7'h13, 7'h33, 7'h0F, 7'h73: begin
        pk_imm  = {in_inst[31:20], 8'h00};
      end
      default: begin
        pk_ill  = 1'b1;
      end
    endcase
  end

  assign in_ready  = (state_q != ST_FULL);
  assign out_valid = (state_q != ST_EMPTY);
  assign accept    = in_valid & in_ready;
  assign drain     = out_valid & out_ready;

  // Next-state and storage steering; flush overrides everything.
  always_comb begin
    state_d = state_q;
    load_m  = 1'b0;
    load_s  = 1'b0;
    move_s  = 1'b0;
    if (flush) begin
      state_d = ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            load_m  = 1'b1;
            state_d = ST_ONE;
          end
        end
        ST_ONE: begin
          if (drain && accept) begin
            load_m  = 1'b1;
          end else if (drain) begin
            state_d = ST_EMPTY;
          end else if (accept) begin
            load_s  = 1'b1;
            state_d = ST_FULL;
          end
        end
        ST_FULL: begin
          if (drain) begin
            move_s  = 1'b1;
            state_d = ST_ONE;
          end
        end
        default: state_d = ST_EMPTY;
      endcase
    end
  end

  // Data next values: main takes a new word or the skid entry, skid takes a new word.
  always_comb begin
    m_imm_d  = m_imm_q;
    m_type_d = m_type_q;
    m_ill_d  = m_ill_q;
    m_tag_d  = m_tag_q;
    s_imm_d  = s_imm_q;
    s_type_d = s_type_q;
    s_ill_d  = s_ill_q;
    s_tag_d  = s_tag_q;
    if (load_m) begin
      m_imm_d  = pk_imm;
      m_type_d = pk_type;
      m_ill_d  = pk_ill;
      m_tag_d  = in_tag;
    end else if (move_s) begin
      m_imm_d  = s_imm_q;
      m_type_d = s_type_q;
      m_ill_d  = s_ill_q;
      m_tag_d  = s_tag_q;
    end
    if (load_s) begin
      s_imm_d  = pk_imm;
      s_type_d = pk_type;
      s_ill_d  = pk_ill;
      s_tag_d  = in_tag;
    end
  end

  // State and main register; main data resets so out_* read as zero after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_EMPTY;
      m_imm_q  <= 20'h0;
      m_type_q <= immt::i;
      m_ill_q  <= 1'b0;
      m_tag_q  <= '0;
    end else begin
      state_q  <= state_d;
      m_imm_q  <= m_imm_d;
      m_type_q <= m_type_d;
      m_ill_q  <= m_ill_d;
      m_tag_q  <= m_tag_d;
    end
  end

  // Skid data is only observed when its valid state bit is set, so it needs no reset.
  always_ff @(posedge clk) begin
    s_imm_q  <= s_imm_d;
    s_type_q <= s_type_d;
    s_ill_q  <= s_ill_d;
    s_tag_q  <= s_tag_d;
  end

  assign out_imm     = m_imm_q;
  assign out_type    = m_type_q;
  assign out_illegal = m_ill_q;
  assign out_tag     = m_tag_q;

endmodule

// File: tb/tb_imm_pack_stage.sv
// tb/tb_imm_pack_stage.sv - self-checking bench for imm_pack_stage
module tb_imm_pack_stage;

  logic            clk;
  logic            rst_n;
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_inst;
  logic [7:0]      in_tag;
  logic            out_valid;
  logic            out_ready;
  logic [19:0]     out_imm;
  immt::imm_type_t out_type;
  logic            out_illegal;
  logic [7:0]      out_tag;

  imm_pack_stage #(.TAG_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_imm(out_imm),
    .out_type(out_type), .out_illegal(out_illegal), .out_tag(out_tag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [19:0]     imm;
    logic            use_imm;
    logic [31:0]     word;
    immt::imm_type_t typ;
    logic            ill;
    logic [7:0]      tag;
  } exp_t;

  typedef struct {
    logic [31:0]     inst;
    logic [19:0]     imm;
    immt::imm_type_t typ;
    logic            ill;
    logic [31:0]     word;
  } vec_t;

  exp_t q[$];
  exp_t nx;
  exp_t e;
  vec_t tbl[11];
  int   total = 0;
  int   bad = 0;
  logic acc;
  logic [6:0] ops[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] unpack(input logic [19:0] imm, input immt::imm_type_t t);
    case (t)
      immt::u: return {imm, 12'h000};
      immt::j: return {{12{imm[19]}}, imm[7:0], imm[8], imm[18:9], 1'b0};
      immt::b: return {{20{imm[19]}}, imm[8], imm[18:13], imm[12:9], 1'b0};
      default: return {{20{imm[19]}}, imm[19:8]};
    endcase
  endfunction

  // Reference: RV32I architectural immediate per format, straight from the ISA layout.
  task automatic set_model(input logic [31:0] inst, input logic [7:0] tag);
    in_inst    = inst;
    in_tag     = tag;
    nx.tag     = tag;
    nx.use_imm = 1'b0;
    nx.imm     = 20'h0;
    nx.ill     = 1'b0;
    nx.typ     = immt::i;
    case (inst[6:0])
      7'h37, 7'h17: begin nx.typ = immt::u; nx.word = {inst[31:12], 12'h000}; end
      7'h6F: begin nx.typ = immt::j; nx.word = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0}; end
      7'h63: begin nx.typ = immt::b; nx.word = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0}; end
      7'h23: nx.word = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      7'h03, 7'h67, 7'h13, 7'h33, 7'h0F, 7'h73: nx.word = {{20{inst[31]}}, inst[31:20]};
      default: begin nx.ill = 1'b1; nx.word = 32'h0; end
    endcase
  endtask

  // Handshakes are judged at the negedge with stable inputs, then one clock is taken.
  task automatic tick();
    if (out_valid && out_ready && !flush) begin
      if (q.size() == 0) begin
        chk("unexpected_output", {24'h0, out_tag}, 32'hFFFFFFFF);
      end else begin
        e = q.pop_front();
        chk("tag", {24'h0, out_tag}, {24'h0, e.tag});
        chk("type", {30'h0, out_type}, {30'h0, e.typ});
        chk("illegal", {31'h0, out_illegal}, {31'h0, e.ill});
        chk("unpacked", unpack(out_imm, out_type), e.word);
        if (e.use_imm) chk("imm", {12'h0, out_imm}, {12'h0, e.imm});
      end
    end
    if (flush) q.delete();
    else if (in_valid && in_ready) q.push_back(nx);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    for (int n = 0; n < 20 && q.size() != 0; n++) tick();
    chk("queue_empty", q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_inst = 32'h0; in_tag = 8'h0;
    nx = '{20'h0, 1'b0, 32'h0, immt::i, 1'b0, 8'h0};

    tbl[0]  = '{32'h123450B7, 20'h12345, immt::u, 1'b0, 32'h12345000};
    tbl[1]  = '{32'hFFF00093, 20'hFFF00, immt::i, 1'b0, 32'hFFFFFFFF};
    tbl[2]  = '{32'hFE000EE3, 20'hFFD00, immt::b, 1'b0, 32'hFFFFFFFC};
    tbl[3]  = '{32'h0020A423, 20'h00800, immt::i, 1'b0, 32'h00000008};
    tbl[4]  = '{32'h0000007F, 20'h00000, immt::i, 1'b1, 32'h00000000};
    tbl[5]  = '{32'h008000EF, 20'h00800, immt::j, 1'b0, 32'h00000008};
    tbl[6]  = '{32'hFFFFF017, 20'hFFFFF, immt::u, 1'b0, 32'hFFFFF000};
    tbl[7]  = '{32'h002081B3, 20'h00200, immt::i, 1'b0, 32'h00000002};
    tbl[8]  = '{32'h00000073, 20'h00000, immt::i, 1'b0, 32'h00000000};
    tbl[9]  = '{32'h80002083, 20'h80000, immt::i, 1'b0, 32'hFFFFF800};
    tbl[10] = '{32'h00000000, 20'h00000, immt::i, 1'b1, 32'h00000000};

    ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73, 7'h7F, 7'h0B};

    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
    chk("rst_in_ready", {31'h0, in_ready}, 32'h1);
    chk("rst_out_imm", {12'h0, out_imm}, 32'h0);
    chk("rst_out_type", {30'h0, out_type}, {30'h0, immt::i});
    chk("rst_out_illegal", {31'h0, out_illegal}, 32'h0);
    chk("rst_out_tag", {24'h0, out_tag}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Table vectors back to back at full throughput.
    out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      in_valid   = 1'b1;
      in_inst    = tbl[k].inst;
      in_tag     = 8'(k + 16);
      nx.imm     = tbl[k].imm;
      nx.use_imm = 1'b1;
      nx.word    = tbl[k].word;
      nx.typ     = tbl[k].typ;
      nx.ill     = tbl[k].ill;
      nx.tag     = 8'(k + 16);
      if (k == 0) chk("empty_before_first", {31'h0, out_valid}, 32'h0);
      tick();
      if (k == 0) begin
        chk("latency_valid", {31'h0, out_valid}, 32'h1);
        chk("lui_imm_direct", {12'h0, out_imm}, 32'h12345);
      end
    end
    in_valid = 1'b0;
    drain();

    // Skid: stalled output, three pushes, release and expect 1,2,3.
    out_ready = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      set_model(32'h00000013 | (32'(t) << 20), 8'(t));
      in_valid = 1'b1;
      if (t == 3) chk("in_ready_full", {31'h0, in_ready}, 32'h0);
      tick();
      chk("stall_tag_stable", {24'h0, out_tag}, 32'h1);
    end
    out_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      acc = in_ready;
      tick();
      if (acc) break;
    end
    in_valid = 1'b0;
    drain();

    // Flush from FULL discards buffered and same-cycle entries.
    out_ready = 1'b0;
    for (int t = 0; t < 2; t++) begin
      set_model(32'h00500013, 8'(t + 40));
      in_valid = 1'b1;
      tick();
    end
    set_model(32'h00900013, 8'h09);
    flush = 1'b1;
    in_valid = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_out_valid", {31'h0, out_valid}, 32'h0);
    chk("flush_in_ready", {31'h0, in_ready}, 32'h1);
    tick();
    chk("flush_stays_empty", {31'h0, out_valid}, 32'h0);

    // Asynchronous reset in the middle of traffic.
    set_model(32'hABCDE0B7, 8'h77);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pre_reset_valid", {31'h0, out_valid}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, out_valid}, 32'h0);
    chk("async_rst_imm", {12'h0, out_imm}, 32'h0);
    chk("async_rst_tag", {24'h0, out_tag}, 32'h0);
    chk("async_rst_in_ready", {31'h0, in_ready}, 32'h1);
    q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Random traffic with random backpressure against the architectural model.
    for (int n = 0; n < 300; n++) begin
      logic [31:0] r;
      r = $urandom();
      set_model({r[31:7], ops[$urandom_range(0, 12)]}, 8'($urandom_range(0, 255)));
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
